// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//
// Registered controller that bridges an Avalon-MM slave port to an external
// asynchronous SRAM (IS61/IDT71 style). It supports a configurable data and
// address width, per-lane byte enables, and programmable read and write wait
// states. Every SRAM pin and the data-bus output enable comes straight from
// a flop, so the strobes are glitch-free. No combinational path runs from the
// slave inputs to the SRAM pins.
//
// Parameters
//   DATA_W   data width in bits (multiple of 8, 8..32)
//   ADDR_W   word address width
//   BE_W     byte-lane count, always DATA_W/8 (derived, do not override)
//   RD_WAIT  extra read access cycles (0..15)
//   WR_WAIT  extra WE_n-low cycles (0..15)
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous active-high reset
//   s_chipselect     slave select
//   s_read           read request
//   s_write          write request (wins when s_read is also high)
//   s_address        word address
//   s_byteenable     write lane enables, active high
//   s_writedata      write data
//   s_readdata       registered read data, held until the next read completes
//   s_readdatavalid  one-cycle pulse marking s_readdata valid
//   s_waitrequest    command stall (the only combinational output)
//   SRAM_DQ          bidirectional SRAM data bus
//   SRAM_ADDR        SRAM address
//   SRAM_BE_n        byte-lane selects, active low
//   SRAM_CE_n        chip enable, active low
//   SRAM_OE_n        output enable, active low
//   SRAM_WE_n        write enable, active low
// ---------------------------------------------------------------------------
module sram_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 18,
  parameter int BE_W    = DATA_W / 8,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_chipselect,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_writedata,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic              s_waitrequest,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [BE_W-1:0]   SRAM_BE_n,
  output logic              SRAM_CE_n,
  output logic              SRAM_OE_n,
  output logic              SRAM_WE_n
);

  // Wait-state reload values for the shared 4-bit down-counter. The counter
  // is loaded with the wait count and the phase ends on the cycle it reads 0,
  // so a phase lasts WAIT+1 cycles.
  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  // Bus phases. A write always gets one setup cycle before WE_n falls and one
  // hold cycle after it rises. That gives the SRAM its address/data setup and
  // hold, and it means DQ is released before any following read lowers OE_n.
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR,
    WR_HOLD
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                ceN_q;
  logic                oeN_q;
  logic                weN_q;
  logic [BE_W-1:0]     beN_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   dqOut_q;
  logic                dqOe_q;
  logic [DATA_W-1:0]   readData_q;
  logic                readValid_q;

  logic                accept;

  // The stall is combinational so the interconnect sees it in the same cycle.
  // It is forced high during reset so that nothing is accepted while the FSM
  // is being cleared.
  assign s_waitrequest = reset | (state_q != IDLE);
  assign accept        = s_chipselect & (s_read | s_write) & ~s_waitrequest;

  // One registered FSM. It produces the next state and every SRAM-facing
  // output in the same step, so each pin changes only on a clock edge.
  // Outputs are set on the edge that enters a phase, not decoded from the
  // current state. The registered pins therefore line up exactly with the
  // phase they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ceN_q       <= 1'b1;
      oeN_q       <= 1'b1;
      weN_q       <= 1'b1;
      beN_q       <= '1;
      addr_q      <= '0;
      dqOut_q     <= '0;
      dqOe_q      <= 1'b0;
      readData_q  <= '0;
      readValid_q <= 1'b0;
    end else begin
      readValid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= s_address;
            ceN_q  <= 1'b0;
            if (s_write) begin
              // Write wins over a simultaneous read. The bus is driven from
              // the setup cycle onward, with WE_n still high.
              state_q <= WR_SETUP;
              oeN_q   <= 1'b1;
              weN_q   <= 1'b1;
              beN_q   <= ~s_byteenable;
              dqOut_q <= s_writedata;
              dqOe_q  <= 1'b1;
            end else begin
              // Reads always fetch the full word. Byte enables apply to
              // writes only.
              state_q <= RD;
              oeN_q   <= 1'b0;
              beN_q   <= '0;
              cnt_q   <= RD_CNT;
            end
          end
        end

        RD: begin
          if (cnt_q == 4'd0) begin
            // Last access cycle. DQ has settled, so it is captured here and
            // the strobes are released so the next cycle is back in IDLE.
            readData_q  <= SRAM_DQ;
            readValid_q <= 1'b1;
            state_q     <= IDLE;
            ceN_q       <= 1'b1;
            oeN_q       <= 1'b1;
            beN_q       <= '1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        WR_SETUP: begin
          // With every lane masked off, WE_n is never pulsed. The phase
          // timing is kept identical so that throughput does not depend on
          // the data.
          state_q <= WR;
          weN_q   <= &beN_q;
          cnt_q   <= WR_CNT;
        end

        WR: begin
          if (cnt_q == 4'd0) begin
            state_q <= WR_HOLD;
            weN_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        WR_HOLD: begin
          // Data is still driven for one cycle after WE_n rises. It is
          // released here, before any read can lower OE_n.
          state_q <= IDLE;
          ceN_q   <= 1'b1;
          beN_q   <= '1;
          dqOe_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          ceN_q   <= 1'b1;
          oeN_q   <= 1'b1;
          weN_q   <= 1'b1;
          beN_q   <= '1;
          dqOe_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pin drivers. These are plain wires from the flops above.
  assign SRAM_ADDR       = addr_q;
  assign SRAM_BE_n       = beN_q;
  assign SRAM_CE_n       = ceN_q;
  assign SRAM_OE_n       = oeN_q;
  assign SRAM_WE_n       = weN_q;
  assign SRAM_DQ         = dqOe_q ? dqOut_q : {DATA_W{1'bz}};
  assign s_readdata      = readData_q;
  assign s_readdatavalid = readValid_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//
// Self-checking bench for sram_ctrl with DATA_W=16, ADDR_W=18, RD_WAIT=1 and
// WR_WAIT=1. A behavioural SRAM answers reads whenever CE_n and OE_n are low
// with WE_n high. It stores the enabled lanes on every cycle where CE_n and
// WE_n are low. A table of single commands with hand-computed results is
// applied first. Hand-written sequences then cover the reset, turnaround and
// select-only corner cases.
//
// Timing bookkeeping: "cycle" counts rising edges. A command accepted at
// edge A is reported with acceptEdge = A. A readdatavalid seen in the cycle
// that ends at edge E is reported as E. Read latency is therefore E - A.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 18;
  localparam int BE_W    = 2;
  localparam int RD_WAIT = 1;
  localparam int WR_WAIT = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_chipselect = 1'b0;
  logic              s_read = 1'b0;
  logic              s_write = 1'b0;
  logic [ADDR_W-1:0] s_address = '0;
  logic [BE_W-1:0]   s_byteenable = '0;
  logic [DATA_W-1:0] s_writedata = '0;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic              s_waitrequest;
  wire  [DATA_W-1:0] SRAM_DQ;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [BE_W-1:0]   SRAM_BE_n;
  logic              SRAM_CE_n;
  logic              SRAM_OE_n;
  logic              SRAM_WE_n;

  sram_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_chipselect   (s_chipselect),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_address      (s_address),
    .s_byteenable   (s_byteenable),
    .s_writedata    (s_writedata),
    .s_readdata     (s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .s_waitrequest  (s_waitrequest),
    .SRAM_DQ        (SRAM_DQ),
    .SRAM_ADDR      (SRAM_ADDR),
    .SRAM_BE_n      (SRAM_BE_n),
    .SRAM_CE_n      (SRAM_CE_n),
    .SRAM_OE_n      (SRAM_OE_n),
    .SRAM_WE_n      (SRAM_WE_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int weLowCount = 0;
  int validCount = 0;
  int busyCount = 0;
  int contentionCount = 0;
  int lastValidEdge = 0;
  logic [15:0] lastValidData = '0;

  // Behavioural SRAM. It drives the bus only during a read access.
  logic [15:0] mem [0:(1<<18)-1];
  logic        modelDrive;
  assign modelDrive = !SRAM_CE_n && !SRAM_OE_n && SRAM_WE_n;
  assign SRAM_DQ    = modelDrive ? mem[SRAM_ADDR] : 16'bz;

  // Edge counter, used to timestamp accepts and readdatavalid pulses.
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // SRAM storage and bus monitor, sampled mid-cycle. A cycle where OE_n is
  // low while the controller still drives DQ counts as contention.
  initial begin
    for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0000;
    forever begin
      @(negedge clk);
      if (!SRAM_CE_n && !SRAM_WE_n) begin
        if (!SRAM_BE_n[0]) mem[SRAM_ADDR][7:0]  = SRAM_DQ[7:0];
        if (!SRAM_BE_n[1]) mem[SRAM_ADDR][15:8] = SRAM_DQ[15:8];
      end
      if (!SRAM_WE_n) weLowCount++;
      if (s_readdatavalid) begin
        validCount++;
        lastValidEdge = cycle + 1;
        lastValidData = s_readdata;
      end
      if (s_waitrequest && !reset) busyCount++;
      if (!SRAM_OE_n && dut.dqOe_q) begin
        contentionCount++;
        $display("[TB] bus contention at edge %0d", cycle + 1);
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    bit          rd;
    bit          wr;
    logic [17:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          expWeLow;
    int          expBusy;
    int          expValids;
    logic [15:0] expData;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one command and holds it until it is accepted. The task returns
  // 1 time unit after the accept edge. It lowers the request and does not
  // wait for an edge, so a following call keeps the request continuous.
  task automatic applyStimulus(input vec_t v, output int acceptEdge, output bit accepted);
    s_chipselect = 1'b1;
    s_read       = v.rd;
    s_write      = v.wr;
    s_address    = v.addr;
    s_byteenable = v.be;
    s_writedata  = v.wdata;
    accepted     = 1'b0;
    acceptEdge   = 0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (!s_waitrequest) begin
        accepted   = 1'b1;
        acceptEdge = cycle + 1;
      end
      @(posedge clk);
      #1;
    end
    s_chipselect = 1'b0;
    s_read       = 1'b0;
    s_write      = 1'b0;
  endtask

  int   acc, acc2, acc3, w0, v0, b0, ceLow;
  bit   ok, ok2, ok3;
  vec_t tv;

  initial begin
    // rd, wr, addr, be, wdata, expWeLow, expBusy, expValids, expData
    vecs[0]  = '{1'b0, 1'b1, 18'h2A5F3, 2'b11, 16'hBEEF, 2, 4, 0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 18'h2A5F3, 2'b11, 16'h0000, 0, 2, 1, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b1, 18'h00010, 2'b11, 16'h0000, 2, 4, 0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 18'h00010, 2'b01, 16'h12AB, 2, 4, 0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 18'h00010, 2'b11, 16'h0000, 0, 2, 1, 16'h00AB};
    vecs[5]  = '{1'b0, 1'b1, 18'h00010, 2'b00, 16'hFFFF, 0, 4, 0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 18'h00010, 2'b11, 16'h0000, 0, 2, 1, 16'h00AB};
    vecs[7]  = '{1'b1, 1'b1, 18'h00007, 2'b11, 16'h5555, 2, 4, 0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 18'h00007, 2'b11, 16'h0000, 0, 2, 1, 16'h5555};
    vecs[9]  = '{1'b0, 1'b1, 18'h00003, 2'b10, 16'hA5C3, 2, 4, 0, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 18'h00003, 2'b11, 16'h0000, 0, 2, 1, 16'hA500};
    vecs[11] = '{1'b0, 1'b1, 18'h3FFFF, 2'b11, 16'hC3A5, 2, 4, 0, 16'h0000};
    vecs[12] = '{1'b1, 1'b0, 18'h3FFFF, 2'b11, 16'h0000, 0, 2, 1, 16'hC3A5};

    // Reset state, then the first cycle after reset.
    @(negedge clk);
    checkOutput("waitrequest during reset", s_waitrequest, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("waitrequest after reset", s_waitrequest, 0);
    checkOutput("CE/OE/WE after reset", {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n}, 3'b111);
    checkOutput("BE_n after reset", SRAM_BE_n, 2'b11);
    checkOutput("ADDR after reset", SRAM_ADDR, 0);
    checkOutput("readdata/valid after reset", {s_readdata, s_readdatavalid}, 0);
    checkOutput("DQ released after reset", dut.dqOe_q, 0);
    @(posedge clk);
    #1;

    // Table of single commands, each run to completion.
    for (int i = 0; i < NVEC; i++) begin
      w0 = weLowCount;
      v0 = validCount;
      b0 = busyCount;
      applyStimulus(vecs[i], acc, ok);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d accepted", i), ok, 1);
      checkOutput($sformatf("v%0d WE_n low cycles", i), weLowCount - w0, vecs[i].expWeLow);
      checkOutput($sformatf("v%0d busy cycles", i), busyCount - b0, vecs[i].expBusy);
      checkOutput($sformatf("v%0d valid pulses", i), validCount - v0, vecs[i].expValids);
      if (vecs[i].expValids == 1) begin
        checkOutput($sformatf("v%0d read latency", i), lastValidEdge - acc, 3);
        checkOutput($sformatf("v%0d readdata", i), lastValidData, vecs[i].expData);
      end
    end

    // Reset held for 3 edges in the middle of a write.
    tv = '{1'b0, 1'b1, 18'h00055, 2'b11, 16'hCAFE, 0, 0, 0, 16'h0000};
    applyStimulus(tv, acc, ok);
    @(posedge clk);
    @(negedge clk);
    checkOutput("WE_n low before reset", SRAM_WE_n, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid-write reset strobes", {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n}, 3'b111);
    checkOutput("mid-write reset BE_n", SRAM_BE_n, 2'b11);
    checkOutput("mid-write reset DQ released", dut.dqOe_q, 0);
    checkOutput("mid-write reset waitrequest", s_waitrequest, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("waitrequest first cycle after reset", s_waitrequest, 0);
    @(posedge clk);
    #1;

    // Reset during the second RD cycle drops the read, and the next read
    // still returns the stored data.
    v0 = validCount;
    tv = '{1'b1, 1'b0, 18'h2A5F3, 2'b11, 16'h0000, 0, 0, 0, 16'h0000};
    applyStimulus(tv, acc, ok);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("aborted read valid pulses", validCount - v0, 0);
    @(posedge clk);
    #1;
    v0 = validCount;
    applyStimulus(tv, acc, ok);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("read after abort valid pulses", validCount - v0, 1);
    checkOutput("read after abort latency", lastValidEdge - acc, 3);
    checkOutput("read after abort data", lastValidData, 16'hBEEF);

    // Read, write, read held back to back, to check turnaround and throughput.
    v0 = validCount;
    tv = '{1'b1, 1'b0, 18'h00001, 2'b11, 16'h0000, 0, 0, 0, 16'h0000};
    applyStimulus(tv, acc, ok);
    tv = '{1'b0, 1'b1, 18'h00002, 2'b11, 16'h1234, 0, 0, 0, 16'h0000};
    applyStimulus(tv, acc2, ok2);
    tv = '{1'b1, 1'b0, 18'h00003, 2'b11, 16'h0000, 0, 0, 0, 16'h0000};
    applyStimulus(tv, acc3, ok3);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("turnaround all accepted", {ok, ok2, ok3}, 3'b111);
    checkOutput("read-to-next accept spacing", acc2 - acc, 3);
    checkOutput("write-to-next accept spacing", acc3 - acc2, 5);
    checkOutput("turnaround valid pulses", validCount - v0, 2);
    checkOutput("turnaround last readdata", lastValidData, 16'hA500);
    tv = '{1'b1, 1'b0, 18'h00002, 2'b11, 16'h0000, 0, 0, 0, 16'h0000};
    applyStimulus(tv, acc, ok);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("turnaround write readback", lastValidData, 16'h1234);

    // Chipselect with no read or write must do nothing.
    b0 = busyCount;
    w0 = weLowCount;
    ceLow = 0;
    s_chipselect = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!SRAM_CE_n) ceLow++;
    end
    s_chipselect = 1'b0;
    checkOutput("select-only CE_n low cycles", ceLow, 0);
    checkOutput("select-only busy cycles", busyCount - b0, 0);
    checkOutput("select-only WE_n low cycles", weLowCount - w0, 0);

    checkOutput("DQ contention cycles", contentionCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
